// File: rtl/ws2811_pkg.sv
// Shared WS2811 timing constants (50 MHz clocks), decoder state encoding and colour word type.
package ws2811_pkg;

    localparam int BIT_PERIOD_CLK = 62;
    localparam int T0H_CLK        = 20;
    localparam int T1H_CLK        = 40;
    localparam int LATCH_CLK      = 2500;
    // Midpoint between the nominal 0 and 1 high times.
    localparam int BIT_THRESH_CLK = (T0H_CLK + T1H_CLK) / 2;
    localparam int WORD_BITS      = 24;

    typedef enum logic [1:0] {
        WAIT_LATCH = 2'd0,
        IDLE       = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } state_t;

    typedef logic [WORD_BITS-1:0] color_t;

endpackage

// File: rtl/ws2811_serial_decoder_if.sv
// Decoded-word and frame-status bus driven by the WS2811 decoder.
interface ws2811_serial_decoder_if;
    import ws2811_pkg::*;

    color_t     led_data;
    logic       led_valid;
    logic [7:0] led_index;
    logic       frame_done;
    logic [7:0] frame_led_count;
    logic       frame_error;

    modport master (
        output led_data, led_valid, led_index,
        output frame_done, frame_led_count, frame_error
    );

    modport slave (
        input led_data, led_valid, led_index,
        input frame_done, frame_led_count, frame_error
    );
endinterface

// File: rtl/ws2811_rx_sync.sv
// 2-FF synchronizer for the asynchronous data line plus registered edge detector.
module ws2811_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync;

    // level is the third stage so it lines up with the rise/fall strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync  <= 2'b00;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[0], din};
            level <= sync[1];
            rise  <= sync[1] & ~level;
            fall  <= ~sync[1] & level;
        end
    end
endmodule

// File: rtl/ws2811_serial_decoder.sv
// WS2811 pulse-width bitstream decoder: recovers 24-bit LED words, frame boundaries and errors.
module ws2811_serial_decoder
    import ws2811_pkg::*;
#(
    parameter int T_BIT_THRESH = BIT_THRESH_CLK,
    parameter int T_MIN_HIGH   = 8,
    parameter int T_MAX_HIGH   = 55,
    parameter int T_LATCH      = LATCH_CLK,
    parameter int MAX_LEDS     = 11
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       serial_in,
    ws2811_serial_decoder_if.master    bus
);
    logic        level, rise, fall;
    state_t      state;
    logic [15:0] cnt;
    logic [22:0] sr;
    logic [4:0]  bit_cnt;
    logic [7:0]  idx;
    logic        bit_val;
    color_t      word_nxt;
    logic        width_bad;
    logic        latch_hit;

    ws2811_rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .din   (serial_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // On a fall cycle cnt equals the number of cycles the line was high.
    assign bit_val   = (cnt >= 16'(T_BIT_THRESH));
    assign word_nxt  = {sr, bit_val};
    assign width_bad = (cnt < 16'(T_MIN_HIGH)) || (cnt > 16'(T_MAX_HIGH));
    assign latch_hit = !level && (cnt >= 16'(T_LATCH));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= WAIT_LATCH;
            cnt                 <= '0;
            sr                  <= '0;
            bit_cnt             <= '0;
            idx                 <= '0;
            bus.led_data        <= '0;
            bus.led_valid       <= 1'b0;
            bus.led_index       <= '0;
            bus.frame_done      <= 1'b0;
            bus.frame_led_count <= '0;
            bus.frame_error     <= 1'b0;
        end else begin
            bus.led_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            if (bus.frame_done)
                bus.frame_error <= 1'b0;

            // The edge cycle is already the first cycle of the new level.
            if (rise || fall)
                cnt <= 16'd1;
            else if (cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;

            case (state)
                WAIT_LATCH: begin
                    if (latch_hit) begin
                        idx     <= '0;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                IDLE: begin
                    if (rise)
                        state <= HIGH;
                end
                HIGH: begin
                    if (fall) begin
                        if (width_bad) begin
                            bus.frame_error <= 1'b1;
                            bit_cnt         <= '0;
                            state           <= WAIT_LATCH;
                        end else begin
                            sr    <= word_nxt[22:0];
                            state <= LOW;
                            if (bit_cnt == 5'(WORD_BITS - 1)) begin
                                bus.led_data  <= word_nxt;
                                bus.led_valid <= 1'b1;
                                bus.led_index <= idx;
                                bit_cnt       <= '0;
                                if (idx != 8'hFF)
                                    idx <= idx + 8'd1;
                                if (int'(idx) >= MAX_LEDS)
                                    bus.frame_error <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else if (level && cnt > 16'(T_MAX_HIGH)) begin
                        // Stuck-high line: flag it now rather than waiting for a fall.
                        bus.frame_error <= 1'b1;
                        bit_cnt         <= '0;
                        state           <= WAIT_LATCH;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                    end else if (latch_hit) begin
                        bus.frame_done      <= 1'b1;
                        bus.frame_led_count <= idx;
                        if (bit_cnt != '0)
                            bus.frame_error <= 1'b1;
                        idx     <= '0;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= WAIT_LATCH;
            endcase
        end
    end
endmodule
